// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressable data memory with a valid/ready request channel and a
// valid/ready response channel. Loads and stores of byte, halfword and word
// size are supported. Every accepted request produces exactly one response
// one cycle after acceptance. Misaligned, illegal-size or out-of-range
// requests fault: they never touch memory and they bump a saturating error
// counter.
//
// Ports
//   clk, reset    : single clock, synchronous active-high reset
//   req_valid     : request present
//   req_ready     : request can be accepted this cycle
//   req_we        : 1 = store, 0 = load
//   req_size      : 00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr      : byte address
//   req_wdata     : store data, right-justified
//   rsp_valid     : response present
//   rsp_ready     : consumer accepts the response
//   rsp_rdata     : extended load data (0 for stores and faults)
//   rsp_err       : request faulted
//   err_cnt       : saturating count of faulted requests
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int unsigned       DEPTH_WORDS = 64,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        err_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic              in_range;
  logic              fault;
  logic              accept;

  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  logic [3:0]        byte_en;
  logic [31:0]       wr_data;

  logic [31:0]       rdata_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;

  // Address decode. The memory spans a power-of-two number of bytes, so an
  // offset is in range exactly when every bit above the word index is zero.
  assign offset   = req_addr - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];
  assign lane     = offset[1:0];
  assign in_range = (offset[ADDR_W-1:IDX_W+2] == '0);

  always_comb begin
    fault = !in_range;
    case (req_size)
      2'b00:   fault = !in_range;
      2'b01:   fault = !in_range || lane[0];
      2'b10:   fault = !in_range || (lane != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Load path: the word is read at acceptance and the addressed lane is
  // extracted and extended. Stores and faults answer with zero data.
  always_comb begin
    rd_word   = mem[word_idx];
    byte_sel  = rd_word[{lane, 3'b000} +: 8];
    half_sel  = rd_word[{lane[1], 4'b0000} +: 16];
    load_data = '0;
    case (req_size)
      2'b00:   load_data = {{24{!req_unsigned && byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{!req_unsigned && half_sel[15]}}, half_sel};
      2'b10:   load_data = rd_word;
      default: load_data = '0;
    endcase
    if (fault || req_we) begin
      load_data = '0;
    end
  end

  // Store path: the right-justified data is replicated across the word so
  // each enabled byte lane already sees its byte without a shifter.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = {4{req_wdata[7:0]}};
    case (req_size)
      2'b00: begin
        byte_en = 4'b0001 << lane;
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wr_data = req_wdata;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

  // Storage is deliberately not reset; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (!reset && accept && req_we && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A new accept always leads to RESP (this also covers the same-cycle
  // retire-and-accept case with no bubble); a retire without an accept
  // drops back to IDLE.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = RESP;
    end else if (rsp_ready) begin
      state_nxt = IDLE;
    end
  end

  // FSM outputs.
  always_comb begin
    rsp_valid = (state == RESP);
  end

  // Response payload and error counter. Payload only changes on accept,
  // which keeps it stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (accept) begin
      rdata_q <= load_data;
      err_q   <= fault;
      if (fault && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl (default parameters). A byte-array
// reference model predicts handshakes, responses and the error counter.
// Directed sequences cover the classic load/store cases, faults,
// backpressure, error-counter saturation and reset, followed by random
// traffic.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam int          DEPTH = 64;
  localparam int          BYTES = DEPTH * 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_cnt;

  data_mem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W     (32),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0]  model_mem [BYTES];
  bit          model_pending = 1'b0;
  logic [31:0] model_rdata   = 32'h0;
  bit          model_err     = 1'b0;
  int          model_errs    = 0;

  // Last observed response, captured while a response is pending.
  logic [31:0] obs_rdata  = 32'h0;
  logic        obs_err    = 1'b0;
  logic [7:0]  obs_errcnt = 8'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit isFault(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= 32'(BYTES)) return 1'b1;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (off % 2) != 0) return 1'b1;
    if (size == 2'd2 && (off % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Little-endian gather of the addressed bytes, then extension.
  function automatic logic [31:0] modelLoad(input logic [1:0] size, input bit uns, input logic [31:0] addr);
    int          off;
    int          n;
    logic [31:0] v;
    off = int'(addr - BASE);
    n   = sizeBytes(size);
    v   = 32'h0;
    for (int i = 0; i < n; i++) begin
      v = v | (32'(model_mem[off+i]) << (8*i));
    end
    if (n < 4 && !uns && v[8*n-1]) begin
      v = v | (32'hFFFF_FFFF << (8*n));
    end
    return v;
  endfunction

  task automatic modelStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int off;
    int n;
    off = int'(addr - BASE);
    n   = sizeBytes(size);
    for (int i = 0; i < n; i++) begin
      model_mem[off+i] = wdata[8*i +: 8];
    end
  endtask

  // One clock cycle: drive at the falling edge, check the settled outputs
  // against the model, then advance the model at the rising edge.
  task automatic applyStimulus(input bit v, input bit we, input logic [1:0] size, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input bit rr);
    bit exp_ready;
    bit acc;
    bit f;
    @(negedge clk);
    req_valid    = v;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    rsp_ready    = rr;
    #1;
    exp_ready = !model_pending || rr;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(model_pending));
    checkOutput("err_cnt", 32'(err_cnt), 32'(model_errs));
    obs_errcnt = err_cnt;
    if (model_pending) begin
      checkOutput("rsp_rdata", rsp_rdata, model_rdata);
      checkOutput("rsp_err", 32'(rsp_err), 32'(model_err));
      obs_rdata = rsp_rdata;
      obs_err   = rsp_err;
    end
    acc = v && exp_ready;
    @(posedge clk);
    if (model_pending && rr) begin
      model_pending = 1'b0;
    end
    if (acc) begin
      f             = isFault(size, addr);
      model_pending = 1'b1;
      model_err     = f;
      if (f) begin
        model_rdata = 32'h0;
        if (model_errs < 255) model_errs++;
      end else if (we) begin
        model_rdata = 32'h0;
        modelStore(size, addr, wdata);
      end else begin
        model_rdata = modelLoad(size, uns, addr);
      end
    end
  endtask

  // Reset while offering a store to 0x10; the store must be ignored.
  task automatic doReset(input int n);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h10;
    req_wdata = 32'h1234_5678;
    rsp_ready = 1'b0;
    repeat (n) @(posedge clk);
    model_pending = 1'b0;
    model_errs    = 0;
    model_rdata   = 32'h0;
    model_err     = 1'b0;
    @(negedge clk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic directedLoad(input string tag, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] exp, input bit exp_err);
    applyStimulus(1'b1, 1'b0, size, uns, addr, 32'h0, 1'b1);
    idleCycle();
    checkOutput(tag, obs_rdata, exp);
    checkOutput({tag, "_err"}, 32'(obs_err), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    bit          v;
    bit          we;
    bit          uns;
    bit          rr;

    doReset(2);

    // Give every byte a known value so random loads have defined answers.
    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, 1'b1);
    end
    idleCycle();

    // Word store then word load.
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
    idleCycle();
    checkOutput("st_word_rdata", obs_rdata, 32'h0);
    checkOutput("st_word_err", 32'(obs_err), 32'h0);
    directedLoad("ld_word_10", 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);

    // Byte store merges into the word; signed and unsigned byte loads.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAA_AA80, 1'b1);
    directedLoad("ld_byte_s", 2'd0, 1'b0, 32'h11, 32'hFFFF_FF80, 1'b0);
    directedLoad("ld_byte_u", 2'd0, 1'b1, 32'h11, 32'h0000_0080, 1'b0);
    directedLoad("ld_word_merged", 2'd2, 1'b0, 32'h10, 32'hDEAD_80EF, 1'b0);
    directedLoad("ld_half_hi_s", 2'd1, 1'b0, 32'h12, 32'hFFFF_DEAD, 1'b0);

    // Four faulting loads.
    directedLoad("flt_half", 2'd1, 1'b0, 32'h13, 32'h0, 1'b1);
    directedLoad("flt_word", 2'd2, 1'b0, 32'h12, 32'h0, 1'b1);
    directedLoad("flt_size", 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    directedLoad("flt_range", 2'd2, 1'b0, 32'(BYTES), 32'h0, 1'b1);
    checkOutput("err_cnt_4", 32'(obs_errcnt), 32'd4);

    // Faulting stores must leave memory alone.
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 32'h12, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 32'(BYTES + 16), 32'h0, 1'b1);
    directedLoad("mem_unchanged", 2'd2, 1'b0, 32'h10, 32'hDEAD_80EF, 1'b0);

    // Backpressure: a held response blocks new requests, then full rate.
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 32'($urandom_range(0, BYTES-1)), 32'h0, 1'b1);
    end
    idleCycle();

    // Error counter saturation.
    repeat (300) applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    idleCycle();
    checkOutput("err_cnt_sat", 32'(obs_errcnt), 32'd255);

    // Reset clears the counter but not memory.
    doReset(1);
    directedLoad("ld_after_rst", 2'd2, 1'b0, 32'h10, 32'hDEAD_80EF, 1'b0);

    // Reset with a stalled response pending.
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    doReset(1);
    directedLoad("no_spurious_wr", 2'd2, 1'b0, 32'h10, 32'hDEAD_80EF, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, BYTES + 31));
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      v   = ($urandom_range(0, 9) < 7);
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 9) < 7);
      applyStimulus(v, we, size, uns, addr, $urandom, rr);
    end
    idleCycle();
    idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
